// File: rtl/aes_round_sequencer.sv
// AES round sequencer: steps the datapath control signals through the
// (Inv)Cipher round schedule. Define AES_SEQ_ENC_EN to add encrypt mode.
module aes_round_sequencer #(
    parameter int NR        = 10,
    parameter int MIX_WORDS = 4
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       AES_START,
    input  logic       MODE,
    output logic       LOAD,
    output logic       UPDATE,
    output logic [2:0] SEL,
    output logic [3:0] KEY_IDX,
    output logic [1:0] WORD,
    output logic       STORE,
    output logic       BUSY,
    output logic       AES_DONE
);

    typedef enum logic [3:0] {
        S_IDLE, S_LOAD, S_ARK0, S_OP_A, S_OP_B, S_MIX, S_ARK, S_STORE, S_DONE
    } state_t;

    localparam logic [2:0] SEL_ARK   = 3'd1;
    localparam logic [2:0] SEL_SHIFT = 3'd2;
    localparam logic [2:0] SEL_SUB   = 3'd3;
    localparam logic [2:0] SEL_MIX   = 3'd4;

    localparam logic [3:0] NR_L      = 4'(NR);
    localparam logic [1:0] WORD_STEP = 2'(4 / MIX_WORDS);
    localparam logic [1:0] LAST_WORD = 2'(4 - 4 / MIX_WORDS);

    state_t     state_q, state_d;
    logic       mode_q, mode_d;     // 1 = decrypt
    logic [3:0] round_q, round_d;
    logic [1:0] word_q, word_d;

`ifndef AES_SEQ_ENC_EN
    logic unused_mode;
    assign unused_mode = MODE;
`endif

    // NOTE: non-blocking assignments so every register updates from its pre-edge value.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q <= S_IDLE;
            mode_q  <= 1'b1;
            round_q <= 4'd0;
            word_q  <= 2'd0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            round_q <= round_d;
            word_q  <= word_d;
        end
    end

    // NOTE: every output and next-state signal gets a default first so no path infers a latch.
    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        round_d  = round_q;
        word_d   = word_q;
        LOAD     = 1'b0;
        SEL      = 3'd0;
        KEY_IDX  = 4'd0;
        WORD     = 2'd0;
        STORE    = 1'b0;
        AES_DONE = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (AES_START) begin
                    state_d = S_LOAD;
`ifdef AES_SEQ_ENC_EN
                    mode_d  = MODE;
`else
                    mode_d  = 1'b1;
`endif
                end
            end
            S_LOAD: begin
                LOAD    = 1'b1;
                round_d = 4'd1;
                word_d  = 2'd0;
                state_d = S_ARK0;
            end
            S_ARK0: begin
                SEL     = SEL_ARK;
                KEY_IDX = mode_q ? NR_L : 4'd0;
                state_d = S_OP_A;
            end
            S_OP_A: begin
                SEL     = mode_q ? SEL_SHIFT : SEL_SUB;
                state_d = S_OP_B;
            end
            S_OP_B: begin
                SEL = mode_q ? SEL_SUB : SEL_SHIFT;
                if (mode_q || round_q == NR_L) begin
                    state_d = S_ARK;
                end else begin
                    state_d = S_MIX;
                end
            end
            S_MIX: begin
                SEL  = SEL_MIX;
                WORD = word_q;
                if (word_q == LAST_WORD) begin
                    word_d = 2'd0;
                    if (mode_q) begin
                        round_d = round_q + 4'd1;
                        state_d = S_OP_A;
                    end else begin
                        state_d = S_ARK;
                    end
                end else begin
                    word_d = word_q + WORD_STEP;
                end
            end
            S_ARK: begin
                SEL     = SEL_ARK;
                KEY_IDX = mode_q ? (NR_L - round_q) : round_q;
                // Decrypt rounds end with MIX, encrypt rounds end here.
                if (round_q == NR_L) begin
                    state_d = S_STORE;
                end else if (mode_q) begin
                    state_d = S_MIX;
                end else begin
                    round_d = round_q + 4'd1;
                    state_d = S_OP_A;
                end
            end
            S_STORE: begin
                STORE   = 1'b1;
                state_d = S_DONE;
            end
            S_DONE: begin
                AES_DONE = 1'b1;
                if (!AES_START) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign UPDATE = (SEL != 3'd0);
    assign BUSY   = (state_q != S_IDLE) && (state_q != S_DONE);

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Self-checking bench for aes_round_sequencer: three parameterisations
// (10/4, 14/1, 12/2) driven from a table of runs plus reset corner cases.
module tb_aes_round_sequencer;

`ifdef AES_SEQ_ENC_EN
    localparam bit ENC = 1'b1;
`else
    localparam bit ENC = 1'b0;
`endif

    typedef struct packed {
        logic       load;
        logic       update;
        logic [2:0] sel;
        logic [3:0] key;
        logic [1:0] word;
        logic       store;
        logic       busy;
        logic       done;
    } outs_t;

    typedef struct {
        int   dut;
        logic mode;
        int   pulse;
        bit   disturb;
        int   hold;
        int   lat;
        int   key0;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] start;
    logic       mode;

    logic       load_w   [3];
    logic       update_w [3];
    logic [2:0] sel_w    [3];
    logic [3:0] key_w    [3];
    logic [1:0] word_w   [3];
    logic       store_w  [3];
    logic       busy_w   [3];
    logic       done_w   [3];

    int n_checks = 0;
    int n_pass   = 0;
    int nr_of [3] = '{10, 14, 12};
    int mw_of [3] = '{4, 1, 2};
    outs_t exp_q[$];
    vec_t  vecs[7];

    always #5 clk = ~clk;

    aes_round_sequencer #(.NR(10), .MIX_WORDS(4)) u_dut0 (
        .CLK(clk), .RESET(rst_n), .AES_START(start[0]), .MODE(mode),
        .LOAD(load_w[0]), .UPDATE(update_w[0]), .SEL(sel_w[0]), .KEY_IDX(key_w[0]),
        .WORD(word_w[0]), .STORE(store_w[0]), .BUSY(busy_w[0]), .AES_DONE(done_w[0])
    );

    aes_round_sequencer #(.NR(14), .MIX_WORDS(1)) u_dut1 (
        .CLK(clk), .RESET(rst_n), .AES_START(start[1]), .MODE(mode),
        .LOAD(load_w[1]), .UPDATE(update_w[1]), .SEL(sel_w[1]), .KEY_IDX(key_w[1]),
        .WORD(word_w[1]), .STORE(store_w[1]), .BUSY(busy_w[1]), .AES_DONE(done_w[1])
    );

    aes_round_sequencer #(.NR(12), .MIX_WORDS(2)) u_dut2 (
        .CLK(clk), .RESET(rst_n), .AES_START(start[2]), .MODE(mode),
        .LOAD(load_w[2]), .UPDATE(update_w[2]), .SEL(sel_w[2]), .KEY_IDX(key_w[2]),
        .WORD(word_w[2]), .STORE(store_w[2]), .BUSY(busy_w[2]), .AES_DONE(done_w[2])
    );

    function automatic outs_t get_outs(input int d);
        outs_t o;
        o.load   = load_w[d];
        o.update = update_w[d];
        o.sel    = sel_w[d];
        o.key    = key_w[d];
        o.word   = word_w[d];
        o.store  = store_w[d];
        o.busy   = busy_w[d];
        o.done   = done_w[d];
        return o;
    endfunction

    function automatic outs_t op(input int sel, input int key, input int word);
        outs_t o = '0;
        o.sel    = 3'(sel);
        o.update = (sel != 0);
        o.key    = 4'(key);
        o.word   = 2'(word);
        o.busy   = 1'b1;
        return o;
    endfunction

    // Expected per-cycle outputs: index k = outputs after the k-th edge past sampling.
    function automatic void build_exp(input int nr, input int mw, input bit dec);
        outs_t o;
        exp_q.delete();
        o = '0; o.load = 1'b1; o.busy = 1'b1;
        exp_q.push_back(o);
        exp_q.push_back(op(1, dec ? nr : 0, 0));
        for (int r = 1; r <= nr; r++) begin
            if (dec) begin
                exp_q.push_back(op(2, 0, 0));
                exp_q.push_back(op(3, 0, 0));
                exp_q.push_back(op(1, nr - r, 0));
                if (r < nr)
                    for (int w = 0; w < mw; w++) exp_q.push_back(op(4, 0, w * (4 / mw)));
            end else begin
                exp_q.push_back(op(3, 0, 0));
                exp_q.push_back(op(2, 0, 0));
                if (r < nr)
                    for (int w = 0; w < mw; w++) exp_q.push_back(op(4, 0, w * (4 / mw)));
                exp_q.push_back(op(1, r, 0));
            end
        end
        o = '0; o.store = 1'b1; o.busy = 1'b1;
        exp_q.push_back(o);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        outs_t act, done_v;
        int    len, first_done, key0, s;
        done_v = '0; done_v.done = 1'b1;
        build_exp(nr_of[v.dut], mw_of[v.dut], v.mode | !ENC);
        len        = exp_q.size();
        first_done = -1;
        key0       = -1;
        @(negedge clk);
        start[v.dut] = 1'b1;
        mode         = v.mode;
        for (int k = 0; k <= len + v.hold; k++) begin
            @(posedge clk);
            @(negedge clk);
            act = get_outs(v.dut);
            if (act.done && first_done < 0) first_done = k;
            if (k == 1) key0 = int'(act.key);
            check($sformatf("run%0d cyc%0d", idx, k), 32'(act),
                  32'((k < len) ? exp_q[k] : done_v));
            s = k + 1;
            if (s < v.pulse) start[v.dut] = 1'b1;
            else if (v.hold > 0 && s >= len - 2 && s <= len + v.hold) start[v.dut] = 1'b1;
            else if (v.disturb && s < len - 2) begin
                start[v.dut] = 1'($urandom_range(0, 1));
                mode         = 1'($urandom_range(0, 1));
            end else start[v.dut] = 1'b0;
        end
        mode = v.mode;
        @(posedge clk);
        @(negedge clk);
        check($sformatf("run%0d idle after done", idx), 32'(get_outs(v.dut)), 32'd0);
        check($sformatf("run%0d latency", idx), 32'(first_done), 32'(v.lat));
        check($sformatf("run%0d ark0 key", idx), 32'(key0), 32'(v.key0));
    endtask

    initial begin
        int    lat;
        outs_t ld_v;

        vecs[0] = '{dut: 0, mode: 1'b1, pulse: 2, disturb: 1'b0, hold: 3, lat: 69, key0: 10};
        vecs[1] = '{dut: 0, mode: 1'b0, pulse: 1, disturb: 1'b0, hold: 0, lat: 69, key0: ENC ? 0 : 10};
        vecs[2] = '{dut: 1, mode: 1'b1, pulse: 3, disturb: 1'b0, hold: 1, lat: 58, key0: 14};
        vecs[3] = '{dut: 2, mode: 1'b1, pulse: 1, disturb: 1'b0, hold: 0, lat: 61, key0: 12};
        vecs[4] = '{dut: 2, mode: 1'b0, pulse: 2, disturb: 1'b0, hold: 2, lat: 61, key0: ENC ? 0 : 12};
        vecs[5] = '{dut: 0, mode: 1'b1, pulse: 1, disturb: 1'b1, hold: 2, lat: 69, key0: 10};
        vecs[6] = '{dut: 0, mode: 1'b0, pulse: 1, disturb: 1'b1, hold: 0, lat: 69, key0: ENC ? 0 : 10};

        rst_n = 1'b0;
        start = 3'b000;
        mode  = 1'b0;
        repeat (2) @(negedge clk);
        for (int d = 0; d < 3; d++)
            check($sformatf("reset state dut%0d", d), 32'(get_outs(d)), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        for (int d = 0; d < 3; d++)
            check($sformatf("idle after release dut%0d", d), 32'(get_outs(d)), 32'd0);

        for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

        // Asynchronous reset in the middle of a run, then an immediate restart.
        @(negedge clk);
        start[0] = 1'b1;
        mode     = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start[0] = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        check("busy before reset", 32'(busy_w[0]), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check("async reset outputs", 32'(get_outs(0)), 32'd0);
        @(posedge clk);
        @(negedge clk);
        check("reset held outputs", 32'(get_outs(0)), 32'd0);
        rst_n    = 1'b1;
        start[0] = 1'b1;
        mode     = 1'b1;
        @(posedge clk);
        @(negedge clk);
        ld_v = '0; ld_v.load = 1'b1; ld_v.busy = 1'b1;
        check("load after release", 32'(get_outs(0)), 32'(ld_v));
        start[0] = 1'b0;
        lat = 0;
        while (!done_w[0] && lat < 200) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        check("latency after reset", 32'(lat), 32'd69);
        @(posedge clk);
        @(negedge clk);
        check("idle after reset run", 32'(get_outs(0)), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
